// File: rtl/set_count_gen.sv
// Self-timed set-membership counter: scans every lattice point of a GRID x GRID field
// and counts those inside the selected set expression of NC circles.
// Optional macro SET_HIT_STREAM_EN exposes a per-point hit stream for bitmap extraction.
module set_count_gen #(
  parameter int GRID = 8,
  parameter int CW   = 4,
  parameter int NC   = 3,
  parameter int CNTW = $clog2(GRID*GRID+1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [2*CW*NC-1:0]   central,
  input  logic [CW*NC-1:0]     radius,
  input  logic [2:0]           mode,
  output logic                 busy,
  output logic                 valid,
  output logic [CNTW-1:0]      candidate
`ifdef SET_HIT_STREAM_EN
  ,
  output logic                 hit_valid,
  output logic                 hit,
  output logic [CW-1:0]        hit_x,
  output logic [CW-1:0]        hit_y
`endif
);

  // Handshake: en is sampled only in IDLE; busy covers SCAN and DONE; valid is a
  // one-cycle strobe and candidate holds its value until the next result.
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  localparam int              DW    = 2*CW+1;
  localparam logic [CW-1:0]   G_C   = CW'(GRID);
  localparam logic [CW-1:0]   GM1_C = CW'(GRID-1);
  localparam logic [CW-1:0]   ONE_C = CW'(1);

  state_e                state_q;
  logic [2*CW*NC-1:0]    cen_q;
  logic [CW*NC-1:0]      rad_q;
  logic [2:0]            mode_q;
  logic [CW-1:0]         x_q, y_q;
  logic [CNTW-1:0]       acc_q;
  logic [7:0]            in_v;
  logic [3:0]            k;
  logic                  hit_w;

  genvar gi;
  for (gi = 0; gi < NC; gi++) begin : g_circ
    logic [CW-1:0] cx, cy, cr, dx, dy;
    logic [DW-1:0] dxe, dye, cre, d2, r2;
    assign cx  = cen_q[(NC-gi)*2*CW-1 -: CW];
    assign cy  = cen_q[(NC-gi)*2*CW-1-CW -: CW];
    assign cr  = rad_q[(NC-gi)*CW-1 -: CW];
    assign dx  = (x_q >= cx) ? x_q - cx : cx - x_q;
    assign dy  = (y_q >= cy) ? y_q - cy : cy - y_q;
    // Widen before squaring so the sum of two squares cannot wrap.
    assign dxe = DW'(dx);
    assign dye = DW'(dy);
    assign cre = DW'(cr);
    assign d2  = dxe*dxe + dye*dye;
    assign r2  = cre*cre;
    assign in_v[gi] = (d2 <= r2);
  end
  for (gi = NC; gi < 8; gi++) begin : g_absent
    assign in_v[gi] = 1'b0;
  end

  always_comb begin
    k     = 4'($countones(in_v));
    hit_w = 1'b0;
    case (mode_q)
      3'd0: hit_w = in_v[0];
      3'd1: hit_w = in_v[0] & in_v[1];
      3'd2: hit_w = in_v[0] ^ in_v[1];
      3'd3: hit_w = ({1'b0, in_v[0]} + {1'b0, in_v[1]} + {1'b0, in_v[2]}) == 2'd2;
      3'd4: hit_w = (k == 4'd1);
      3'd5: hit_w = (k >= 4'd1);
      3'd6: hit_w = (k == 4'(NC));
      3'd7: hit_w = (k >= 4'd2);
      default: hit_w = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cen_q     <= '0;
      rad_q     <= '0;
      mode_q    <= '0;
      x_q       <= ONE_C;
      y_q       <= ONE_C;
      acc_q     <= '0;
      busy      <= 1'b0;
      valid     <= 1'b0;
      candidate <= '0;
    end else begin
      valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (en) begin
            cen_q   <= central;
            rad_q   <= radius;
            mode_q  <= mode;
            acc_q   <= '0;
            x_q     <= ONE_C;
            y_q     <= ONE_C;
            busy    <= 1'b1;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          acc_q <= acc_q + CNTW'(hit_w);
          if (x_q == G_C) begin
            x_q <= ONE_C;
            y_q <= y_q + ONE_C;
          end else begin
            x_q <= x_q + ONE_C;
          end
          // The last point (GRID,GRID) is evaluated in DONE.
          if (x_q == GM1_C && y_q == G_C) state_q <= DONE;
        end
        DONE: begin
          candidate <= acc_q + CNTW'(hit_w);
          valid     <= 1'b1;
          busy      <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SET_HIT_STREAM_EN
  assign hit_valid = (state_q == SCAN) || (state_q == DONE);
  assign hit       = hit_w;
  assign hit_x     = x_q;
  assign hit_y     = y_q;
`endif

endmodule
